stream_packet_fifo: RTL and testbench
=====================================

// Module: stream_packet_fifo
// PURPOSE
//  Store-and-forward packet buffer on the stream_arbiter master side (m_data/m_qos/m_id/m_last).
//  Holds each packet until its last word is written, then releases it, so the consumer sees no mid-packet bubbles.
//  Carries QoS and ID per word. Has a cut-through fallback so a packet longer than DEPTH cannot deadlock.
// PARAMETERS
//  T_DATA_WIDTH  8  data word width
//  T_QOS__WIDTH  4  QoS field width
//  T_ID___WIDTH  1  stream ID width (matches arbiter m_id_o)
//  DEPTH         16 word capacity; power of two, >= 2
// PORTS
//  clk        in   1             single clock, rising edge
//  rst        in   1             asynchronous, active-high reset
//  s_data_i   in   T_DATA_WIDTH  input word (from arbiter m_data_o)
//  s_qos_i    in   T_QOS__WIDTH  input QoS
//  s_id_i     in   T_ID___WIDTH  input ID
//  s_last_i   in   1             last word of packet
//  s_valid_i  in   1             input valid
//  s_ready_o  out  1             input ready (to arbiter m_ready_i)
//  m_data_o   out  T_DATA_WIDTH  output word
//  m_qos_o    out  T_QOS__WIDTH  output QoS
//  m_id_o     out  T_ID___WIDTH  output ID
//  m_last_o   out  1             output last
//  m_valid_o  out  1             output valid
//  m_ready_i  in   1             output ready
//  used_o     out  $clog2(DEPTH)+1  words stored, committed or not
//  fallback_o out  1             high while in FALLBACK state
// BEHAVIOUR
//  - Pointers: wr_ptr, cm_ptr (commit), rd_ptr. Each is $clog2(DEPTH)+1 bits; the MSB is the wrap bit and arithmetic is modulo 2*DEPTH.
//  - full = (wr_ptr - rd_ptr) == DEPTH. used_o = wr_ptr - rd_ptr.
//  - s_ready_o = !full && !rst. It is registered-state only, with no combinational path from m_ready_i.
//    Consequence: a write is refused when full, even if a read happens in the same cycle.
//  - Write: on s_valid_i && s_ready_o, store {data,qos,id,last} at wr_ptr; wr_ptr += 1.
//  - Read: m_valid_o = (rd_ptr != cm_ptr). m_* are driven combinationally from mem[rd_ptr].
//    On m_valid_o && m_ready_i, rd_ptr += 1. m_* must hold stable while m_valid_o && !m_ready_i.
//  - FSM, state NORMAL:
//      on a write with s_last_i, cm_ptr <= wr_ptr+1.
//      If full && cm_ptr == rd_ptr (the buffer holds only one partial packet), go to FALLBACK next cycle.
//  - FSM, state FALLBACK:
//      cm_ptr <= wr_ptr (after any write this cycle), so every stored word is readable.
//      On a write with s_last_i, go to NORMAL; cm_ptr covers that word.
//  - Latency: a last word written in cycle N gives m_valid_o = 1 in cycle N+1 (when the buffer was empty).
//    In FALLBACK, a word written in cycle N is readable in cycle N+1.
//  - Simultaneous write and read: both take effect in the same cycle. used_o is unchanged.
//  - Single-word packet (s_last_i on first word): committed immediately, same as any last word.
//  - Reset (async, any time, including mid-packet): wr/cm/rd_ptr = 0, state = NORMAL.
//    Outputs: m_valid_o = 0, used_o = 0, fallback_o = 0, s_ready_o = 0 while rst is high and 1 after release.
//    Memory contents are not cleared. A partial packet is discarded.
//  - The block does not inspect ID or QoS. The input ID may change only at packet boundaries, as guaranteed by the arbiter.
// STRUCTURE
//  - stream_pkg: typedef struct packed {data, qos, id, last} stream_word_t, parameterised via localparams.
//    Also holds the FSM enum fifo_state_e {NORMAL, FALLBACK}.
//  - Sub-module stream_fifo_mem: simple dual-port RAM, DEPTH x $bits(stream_word_t).
//    Synchronous write, asynchronous read, no reset.
//  - Top: pointers, FSM, handshake logic.
// TESTING
//  1. Reset, then a 3-word packet AA,BB,CC(last), id=0, qos=3, with m_ready_i=1
//     -> m_valid_o stays 0 until the cycle after CC is written; then AA,BB,CC on consecutive cycles with m_last_o on CC.
//  2. Two back-to-back packets {11(last)} id=1 and {22,33(last)} id=0, with m_ready_i=0 for 10 cycles and then 1
//     -> used_o = 3, then output 11(last,id1), 22, 33(last,id0). No bubbles between words.
//  3. DEPTH=16, one 20-word packet with m_ready_i=1
//     -> s_ready_o drops at used_o = 16; fallback_o rises the next cycle; words drain in order.
//     -> fallback_o falls after word 20 (last) is written; all 20 words are output.
//  4. Fill to 16 with complete packets, m_ready_i=1, s_valid_i=1
//     -> a write is refused in the first full cycle; it is accepted on the next cycle.
//  5. Assert rst mid-packet (2 of 4 words written, one earlier committed packet partly read)
//     -> m_valid_o = 0 and used_o = 0 immediately. After release, a new packet 5A(last) comes out alone.
//  6. m_ready_i toggling 1,0,1,0 during a 4-word packet
//     -> m_* hold stable while stalled; order and last flag are preserved.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared word layout and FSM states for the
// store-and-forward stream packet buffer.
package stream_pkg;

   localparam int STREAM_DATA_W = 8;
   localparam int STREAM_QOS_W  = 4;
   localparam int STREAM_ID_W   = 1;
   localparam int STREAM_DEPTH  = 16;

   typedef struct packed {
      logic [STREAM_DATA_W-1:0] data;
      logic [STREAM_QOS_W-1:0]  qos;
      logic [STREAM_ID_W-1:0]   id;
      logic                     last;
   } stream_word_t;

   typedef enum logic {
      NORMAL,
      FALLBACK
   } fifo_state_e;

endpackage

// File: rtl/stream_fifo_mem.sv
// Simple dual-port word store: synchronous write,
// asynchronous read, no reset.
module stream_fifo_mem
   import stream_pkg::*;
#(
   parameter int W     = $bits(stream_word_t),
   parameter int DEPTH = STREAM_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stream_packet_fifo.sv
// Store-and-forward packet buffer with a cut-through
// fallback for packets longer than the buffer.
module stream_packet_fifo
   import stream_pkg::*;
#(
   parameter int T_DATA_WIDTH = STREAM_DATA_W,
   parameter int T_QOS__WIDTH = STREAM_QOS_W,
   parameter int T_ID___WIDTH = STREAM_ID_W,
   parameter int DEPTH        = STREAM_DEPTH,
   localparam int PW          = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [T_DATA_WIDTH-1:0] s_data_i,
   input  logic [T_QOS__WIDTH-1:0] s_qos_i,
   input  logic [T_ID___WIDTH-1:0] s_id_i,
   input  logic                    s_last_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   output logic [T_DATA_WIDTH-1:0] m_data_o,
   output logic [T_QOS__WIDTH-1:0] m_qos_o,
   output logic [T_ID___WIDTH-1:0] m_id_o,
   output logic                    m_last_o,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic [PW-1:0]           used_o,
   output logic                    fallback_o
);

   localparam int AW = PW - 1;
   localparam int W  = T_DATA_WIDTH + T_QOS__WIDTH + T_ID___WIDTH + 1;

   logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr, cm_nxt;
   fifo_state_e   state, state_nxt;
   logic          full, wr_en, rd_en;
   logic [W-1:0]  wr_word, rd_word;

   assign used_o     = wr_ptr - rd_ptr;
   assign full       = used_o == PW'(DEPTH);
   assign s_ready_o  = !full && !rst;
   assign wr_en      = s_valid_i && s_ready_o;
   assign m_valid_o  = rd_ptr != cm_ptr;
   assign rd_en      = m_valid_o && m_ready_i;
   assign fallback_o = state == FALLBACK;

   assign wr_word = {s_data_i, s_qos_i, s_id_i, s_last_i};
   assign {m_data_o, m_qos_o, m_id_o, m_last_o} = rd_word;

   stream_fifo_mem #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wr_word),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_word)
   );

   always_comb begin
      state_nxt = state;
      cm_nxt    = cm_ptr;
      case (state)
         NORMAL: begin
            if (wr_en && s_last_i) cm_nxt = wr_ptr + PW'(1);
            // full with nothing committed: one packet fills the buffer
            if (full && cm_ptr == rd_ptr) state_nxt = FALLBACK;
         end
         FALLBACK: begin
            cm_nxt = wr_ptr + PW'(wr_en);
            if (wr_en && s_last_i) state_nxt = NORMAL;
         end
         default: state_nxt = NORMAL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         cm_ptr <= '0;
         rd_ptr <= '0;
         state  <= NORMAL;
      end else begin
         wr_ptr <= wr_ptr + PW'(wr_en);
         rd_ptr <= rd_ptr + PW'(rd_en);
         cm_ptr <= cm_nxt;
         state  <= state_nxt;
      end
   end

endmodule

// File: tb/tb_stream_packet_fifo.sv
// Randomized bench for stream_packet_fifo against a
// queue-based packet buffer model.
module tb_stream_packet_fifo;
   import stream_pkg::*;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_data = '0;
   logic [3:0] s_qos = '0;
   logic [0:0] s_id = '0;
   logic       s_last = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] m_data;
   logic [3:0] m_qos;
   logic [0:0] m_id;
   logic       m_last;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [4:0] used;
   logic       fallback;

   stream_packet_fifo #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_data_i   (s_data),
      .s_qos_i    (s_qos),
      .s_id_i     (s_id),
      .s_last_i   (s_last),
      .s_valid_i  (s_valid),
      .s_ready_o  (s_ready),
      .m_data_o   (m_data),
      .m_qos_o    (m_qos),
      .m_id_o     (m_id),
      .m_last_o   (m_last),
      .m_valid_o  (m_valid),
      .m_ready_i  (m_ready),
      .used_o     (used),
      .fallback_o (fallback)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   stream_word_t mq[$];
   int           ncommit = 0;
   bit           fb = 0;

   stream_word_t cur;
   bit           pend = 0;
   bit           new_ok = 1;
   int           rem = 0;
   logic [0:0]   pkt_id;
   logic [3:0]   pkt_qos;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
      check("m_valid", 32'(m_valid), 32'(ncommit > 0));
      check("used", 32'(used), 32'(mq.size()));
      check("fallback", 32'(fallback), 32'(fb));
      if (ncommit > 0) begin
         check("m_data", 32'(m_data), 32'(mq[0].data));
         check("m_qos", 32'(m_qos), 32'(mq[0].qos));
         check("m_id", 32'(m_id), 32'(mq[0].id));
         check("m_last", 32'(m_last), 32'(mq[0].last));
      end
   endtask

   task automatic model_step(input bit wr, input bit rd,
                             input stream_word_t w);
      bit was_full;
      int nc0;
      was_full = mq.size() == DEPTH;
      nc0 = ncommit;
      if (rd) begin
         void'(mq.pop_front());
         ncommit--;
      end
      if (wr) mq.push_back(w);
      if (!fb) begin
         // a last word makes everything stored readable
         if (wr && w.last) ncommit = mq.size();
         if (was_full && nc0 == 0) fb = 1;
      end else begin
         ncommit = mq.size();
         if (wr && w.last) fb = 0;
      end
   endtask

   task automatic run(input int n, input int vp, input int rp,
                      input int minl, input int maxl);
      bit wr, rd;
      stream_word_t w;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_outputs();
         if (!pend && (rem > 0 || new_ok) &&
             $urandom_range(99) < vp) begin
            if (rem == 0) begin
               rem = $urandom_range(maxl, minl);
               pkt_id = 1'($urandom);
               pkt_qos = 4'($urandom);
            end
            cur.data = 8'($urandom);
            cur.qos = pkt_qos;
            cur.id = pkt_id;
            cur.last = rem == 1;
            pend = 1;
         end
         s_valid = pend;
         s_data = cur.data;
         s_qos = cur.qos;
         s_id = cur.id;
         s_last = cur.last;
         m_ready = $urandom_range(99) < rp;
         wr = pend && (mq.size() < DEPTH);
         rd = (ncommit > 0) && m_ready;
         w = cur;
         @(posedge clk);
         model_step(wr, rd, w);
         if (wr) begin
            pend = 0;
            rem--;
         end
      end
   endtask

   task automatic flush();
      int k;
      new_ok = 0;
      k = 0;
      while ((pend || rem > 0 || mq.size() > 0) && k < 400) begin
         run(1, 100, 100, 1, 1);
         k++;
      end
      check("flush_timeout", 32'(k < 400), 32'(1));
      new_ok = 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      s_valid = 1'b0;
      #1;
      check("rst_used", 32'(used), 32'(0));
      check("rst_m_valid", 32'(m_valid), 32'(0));
      check("rst_s_ready", 32'(s_ready), 32'(0));
      check("rst_fallback", 32'(fallback), 32'(0));
      mq.delete();
      ncommit = 0;
      fb = 0;
      pend = 0;
      rem = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int k;
      cur = '0;
      pkt_id = '0;
      pkt_qos = '0;
      #2;
      check("init_used", 32'(used), 32'(0));
      check("init_m_valid", 32'(m_valid), 32'(0));
      check("init_s_ready", 32'(s_ready), 32'(0));
      check("init_fallback", 32'(fallback), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      run(150, 100, 100, 1, 4);
      flush();
      run(10, 100, 0, 1, 3);
      run(60, 100, 100, 1, 3);
      flush();
      run(60, 100, 100, 20, 20);
      flush();
      run(200, 100, 30, 1, 3);
      flush();
      run(200, 100, 50, 1, 4);

      k = 0;
      while (!(rem > 0 && rem < 4 && ncommit > 0) && k < 500) begin
         run(1, 70, 30, 4, 4);
         k++;
      end
      check("midpkt_timeout", 32'(k < 500), 32'(1));
      do_reset();
      run(20, 100, 100, 1, 1);
      flush();

      run(2000, 70, 50, 1, 24);
      flush();
      run(1000, 90, 20, 1, 40);
      flush();
      do_reset();
      run(50, 100, 100, 1, 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
